// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for the DE board.
// KEY[1] (active low) latches dividend/divisor from SW and starts a
// shift-and-subtract division that retires one quotient bit per clock.
// LEDR shows quotient, remainder, a done flag and a divide-by-zero flag.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;

  // KEY[1] synchronizer (s1, s2) and edge-detect delay flop (s3)
  logic             s1_r;
  logic             s2_r;
  logic             s3_r;
  logic             start_s;

  // working registers
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_s;
  logic [2:0]       count_r;
  logic [2:0]       count_s;
  logic [9:0]       ledr_r;
  logic [9:0]       ledr_s;

  // one restoring-division step
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   quo_shift_s;
  logic             fits_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

  // operand fields taken from the switches
  logic [WIDTH-1:0] sw_a_s;
  logic [WIDTH-1:0] sw_b_s;
  logic             unused_sw_s;

  assign sw_a_s      = SW[WIDTH-1:0];
  assign sw_b_s      = SW[2*WIDTH-1:WIDTH];
  // switches above the operand fields are intentionally ignored
  assign unused_sw_s = ^SW;

  // falling edge of the synchronized key: exactly one cycle per press
  assign start_s = s3_r & ~s2_r;

  // Bring the next quotient bit down next to the partial remainder and
  // try subtracting the divisor; a clear sign bit means the divisor fits.
  assign shifted_s   = {rem_r, quo_r[WIDTH-1]};
  assign trial_s     = shifted_s - {1'b0, div_r};
  assign fits_s      = ~trial_s[WIDTH];
  assign quo_shift_s = {quo_r, fits_s};
  assign step_quo_s  = quo_shift_s[WIDTH-1:0];
  assign step_rem_s  = fits_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

  // Place quotient, remainder and flags in their LEDR fields; unused LEDs stay dark.
  function automatic logic [9:0] pack_leds(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r,
    input logic             done_flag,
    input logic             div0_flag
  );
    logic [9:0] v;
    v                   = 10'd0;
    v[WIDTH-1:0]        = q;
    v[2*WIDTH-1:WIDTH]  = r;
    v[8]                = done_flag;
    v[9]                = div0_flag;
    return v;
  endfunction

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    quo_s   = quo_r;
    div_s   = div_r;
    count_s = count_r;
    ledr_s  = ledr_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_s) begin
          div_s     = sw_b_s;
          count_s   = 3'd0;
          ledr_s[8] = 1'b0;
          ledr_s[9] = 1'b0;
          if (sw_b_s == {WIDTH{1'b0}}) begin
            // divide by zero: report all-ones quotient and A as remainder
            state_s = DONE;
            rem_s   = sw_a_s;
            quo_s   = {WIDTH{1'b1}};
            ledr_s  = pack_leds({WIDTH{1'b1}}, sw_a_s, 1'b1, 1'b1);
          end else begin
            state_s = CALC;
            rem_s   = {WIDTH{1'b0}};
            quo_s   = sw_a_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      CALC: begin
        rem_s   = step_rem_s;
        quo_s   = step_quo_s;
        count_s = count_r + 3'd1;
        if (count_r == 3'(WIDTH - 1)) begin
          state_s = DONE;
          ledr_s  = pack_leds(step_quo_s, step_rem_s, 1'b1, 1'b0);
        end else begin
          state_s = CALC;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, working registers, LED register and key synchronizer; KEY[0] low resets.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      state_r <= IDLE;
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      div_r   <= {WIDTH{1'b0}};
      count_r <= 3'd0;
      ledr_r  <= 10'd0;
      s1_r    <= 1'b1;
      s2_r    <= 1'b1;
      s3_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      quo_r   <= quo_s;
      div_r   <= div_s;
      count_r <= count_s;
      ledr_r  <= ledr_s;
      s1_r    <= KEY[1];
      s2_r    <= s1_r;
      s3_r    <= s2_r;
    end
  end

  assign LEDR = ledr_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=4).
module tb_seq_divider;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  int         checks = 0;
  int         errors = 0;
  int         lat;

  seq_divider #(.WIDTH(4)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .LEDR     (ledr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press KEY[1] with the given operands; lat = edge (counted from the first
  // low sample) at which done is seen high, from edge 3 on; 0 if never.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat_o);
    lat_o  = 0;
    sw     = {2'b00, b, a};
    key[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) key[1] = 1'b1;
      if (k >= 3 && ledr[8] === 1'b1) begin
        lat_o = k;
        break;
      end
    end
  endtask

  function automatic logic [9:0] expect_leds(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q;
    logic [3:0] r;
    if (b == 4'd0) begin
      return {1'b1, 1'b1, a, 4'hF};
    end else begin
      q = a / b;
      r = a % b;
      return {1'b0, 1'b1, r, q};
    end
  endfunction

  initial begin
    key = 2'b10;
    sw  = 10'd0;
    repeat (3) tick();
    check("reset_ledr", {22'd0, ledr}, 32'h0);
    key[0] = 1'b1;
    repeat (2) tick();
    check("idle_after_reset", {22'd0, ledr}, 32'h0);

    // 1: 13/3
    run_op(4'd13, 4'd3, lat);
    check("t1_latency", lat, 7);
    check("t1_ledr", {22'd0, ledr}, 32'h114);

    // 2: 15/1 and 2/7
    run_op(4'd15, 4'd1, lat);
    check("t2a_latency", lat, 7);
    check("t2a_ledr", {22'd0, ledr}, 32'h10F);
    run_op(4'd2, 4'd7, lat);
    check("t2b_latency", lat, 7);
    check("t2b_ledr", {22'd0, ledr}, 32'h120);

    // 3: divide by zero resolves at edge 3
    run_op(4'd5, 4'd0, lat);
    check("t3_latency", lat, 3);
    check("t3_ledr", {22'd0, ledr}, 32'h35F);
    repeat (3) tick();
    check("t3_hold", {22'd0, ledr}, 32'h35F);

    // 4: second press during CALC is ignored
    sw     = {2'b00, 4'd3, 4'd13};
    key[1] = 1'b0;
    tick();                       // edge 1
    key[1] = 1'b1;
    repeat (3) tick();            // edges 2..4
    sw     = {2'b00, 4'd2, 4'd9};
    key[1] = 1'b0;
    tick();                       // edge 5
    key[1] = 1'b1;
    tick();                       // edge 6
    check("t4_calc_done_low", {31'd0, ledr[8]}, 32'h0);
    tick();                       // edge 7
    check("t4_first_result", {22'd0, ledr}, 32'h114);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_restart", {22'd0, ledr}, 32'h114);
    end
    run_op(4'd9, 4'd2, lat);
    check("t4_second_latency", lat, 7);
    check("t4_second_ledr", {22'd0, ledr}, 32'h114);

    // 5: reset during CALC aborts
    sw     = {2'b00, 4'd5, 4'd12};
    key[1] = 1'b0;
    tick();                       // edge 1
    key[1] = 1'b1;
    repeat (3) tick();            // edges 2..4
    check("t5_calc_hold", {22'd0, ledr}, 32'h014);
    key[0] = 1'b0;
    tick();                       // edge 5
    check("t5_reset_abort", {22'd0, ledr}, 32'h0);
    key[0] = 1'b1;
    repeat (5) tick();
    check("t5_idle", {22'd0, ledr}, 32'h0);
    run_op(4'd12, 4'd5, lat);
    check("t5_latency", lat, 7);
    check("t5_ledr", {22'd0, ledr}, 32'h122);

    // 6: exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), lat);
        check("t6_ledr", {22'd0, ledr}, {22'd0, expect_leds(4'(a), 4'(b))});
        if (b != 0) begin
          check("t6_latency", lat, 7);
          check("t6_contract", 32'(ledr[3:0]) * 32'(b) + 32'(ledr[7:4]), 32'(a));
          check("t6_rem_lt_b", {31'd0, (32'(ledr[7:4]) < 32'(b))}, 32'h1);
        end else begin
          check("t6_div0_latency", lat, 3);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
